// File: rtl/i2c_read_scheduler_pkg.sv
// Shared constants for the I2C read scheduler: FSM encoding and bus widths.
package i2c_sched_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int ID_W   = 3;
    localparam logic [DATA_W-1:0] ERR_DATA = 16'h0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
endpackage

// File: rtl/i2c_read_scheduler_if.sv
// Requester / engine / response signals of the scheduler, bundled as one interface.
interface i2c_read_scheduler_if
    import i2c_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    logic                              sched_en;
    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr;
    logic                              eng_start;
    logic [ADDR_W-1:0]                 eng_addr;
    logic                              eng_abort;
    logic                              eng_done;
    logic                              eng_nack;
    logic [DATA_W-1:0]                 eng_data;
    logic                              busy;
    logic                              rsp_valid;
    logic [ID_W-1:0]                   rsp_id;
    logic [DATA_W-1:0]                 rsp_data;
    logic                              rsp_err;

    modport master (
        input  sched_en, req, req_addr, eng_done, eng_nack, eng_data,
        output eng_start, eng_addr, eng_abort, busy, rsp_valid, rsp_id, rsp_data, rsp_err
    );
    modport slave (
        output sched_en, req, req_addr, eng_done, eng_nack, eng_data,
        input  eng_start, eng_addr, eng_abort, busy, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/i2c_read_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after i_last, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);
    // Scan from farthest to nearest so the nearest candidate is assigned last.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NUM_REQ]) begin
                o_winner = IDX_W'((int'(i_last) + k) % NUM_REQ);
                o_any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_read_scheduler.sv
// Shares one 16-bit I2C read engine among NUM_REQ requesters with round-robin
// grants, a per-transaction watchdog and a one-cycle registered response pulse.
module i2c_read_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    i2c_read_scheduler_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  r_gid;
    logic [WD_W-1:0]   r_wd;
    logic [DATA_W-1:0] r_cap_data;
    logic              r_cap_nack;
    logic              r_tmo;
    logic              r_eng_start;
    logic [ADDR_W-1:0] r_eng_addr;
    logic              r_eng_abort;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic [IDX_W-1:0]  w_winner;
    logic              w_any;
    logic              w_err;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .i_req    (bus.req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_err = r_cap_nack | r_tmo;

    // Outputs are registered, so each pulse appears one cycle after its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_gid       <= '0;
            r_wd        <= '0;
            r_cap_data  <= '0;
            r_cap_nack  <= 1'b0;
            r_tmo       <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_addr  <= '0;
            r_eng_abort <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            r_eng_abort <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.sched_en && w_any) begin
                        r_gid      <= w_winner;
                        r_last     <= w_winner;
                        r_eng_addr <= bus.req_addr[w_winner];
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    r_eng_start <= 1'b1;
                    r_wd        <= '0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the expiry cycle takes priority over the abort.
                    if (bus.eng_done) begin
                        r_cap_data <= bus.eng_data;
                        r_cap_nack <= bus.eng_nack;
                        r_tmo      <= 1'b0;
                        r_state    <= ST_RESP;
                    end else if (r_wd == WD_LAST) begin
                        r_eng_abort <= 1'b1;
                        r_cap_nack  <= 1'b0;
                        r_tmo       <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= ID_W'(r_gid);
                    r_rsp_err   <= w_err;
                    r_rsp_data  <= w_err ? ERR_DATA : r_cap_data;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.eng_start = r_eng_start;
    assign bus.eng_addr  = r_eng_addr;
    assign bus.eng_abort = r_eng_abort;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_i2c_read_scheduler.sv
// Self-checking bench: directed boundary cases plus randomized transactions
// against a queue-based round-robin model; watchdog shortened to 150 cycles.
module tb_i2c_read_scheduler;
    localparam int NR = 4;
    localparam int TO = 150;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    i2c_read_scheduler_if #(.NUM_REQ(NR)) bus ();

    i2c_read_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int n_start = 0;
    int n_abort = 0;
    int cyc = 0;
    int start_cyc = 0;
    int abort_cyc = 0;
    logic [6:0] addr [NR];
    int order [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.eng_start) begin n_start++; start_cyc = cyc; end
        if (bus.eng_abort) begin n_abort++; abort_cyc = cyc; end
    endtask

    // Priority list: first entry with a pending request wins; after a grant
    // the list restarts at the id following the winner.
    function automatic int model_pick(input logic [NR-1:0] r);
        foreach (order[i]) if (r[order[i]]) return order[i];
        return 0;
    endfunction

    function automatic void model_grant(input int w);
        order.delete();
        for (int k = 1; k <= NR; k++) order.push_back((w + k) % NR);
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = '0;
        bus.sched_en = 1'b0;
        bus.eng_done = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        model_grant(NR - 1);
        bus.sched_en = 1'b1;
    endtask

    task automatic wait_start(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            tick();
            if (bus.eng_start) ok = 1'b1;
        end
        chk({tag, " start_seen"}, 32'(ok), 32'd1);
    endtask

    // Engine answers lat cycles after eng_start; returns right after the response pulse edge.
    task automatic respond(input int lat, input logic nack, input logic [15:0] data);
        repeat (lat - 1) tick();
        bus.eng_done = 1'b1;
        bus.eng_nack = nack;
        bus.eng_data = data;
        tick();
        bus.eng_done = 1'b0;
        bus.eng_nack = 1'b0;
        bus.eng_data = 16'($urandom);
        tick();
    endtask

    task automatic chk_rsp(input string tag, input int id, input logic err, input logic [15:0] data);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, " rsp_id"},    32'(bus.rsp_id),    32'(id));
        chk({tag, " rsp_err"},   32'(bus.rsp_err),   32'(err));
        chk({tag, " rsp_data"},  32'(bus.rsp_data),  err ? 32'd0 : 32'(data));
    endtask

    task automatic txn(input string tag, input logic [NR-1:0] r, input bit drop,
                       input int lat, input logic nack, input logic [15:0] data, output int w);
        int e;
        bus.req = r;
        e = model_pick(r);
        wait_start(tag);
        chk({tag, " eng_addr"}, 32'(bus.eng_addr), 32'(addr[e]));
        model_grant(e);
        w = e;
        if (drop) bus.req = NR'($urandom);
        respond(lat, nack, data);
        chk_rsp(tag, e, nack, data);
    endtask

    initial begin
        int w, prev, ns, na, e;
        bit seen;
        logic [15:0] d;
        logic [NR-1:0] r;

        bus.req = '0;
        bus.sched_en = 1'b0;
        bus.eng_done = 1'b0;
        bus.eng_nack = 1'b0;
        bus.eng_data = '0;
        addr[0] = 7'h48;
        for (int i = 1; i < NR; i++) addr[i] = 7'h48 + 7'(i);
        for (int i = 0; i < NR; i++) bus.req_addr[i] = addr[i];

        // Reset state
        #2;
        chk("rst eng_start", 32'(bus.eng_start), 32'd0);
        chk("rst eng_addr",  32'(bus.eng_addr),  32'd0);
        chk("rst eng_abort", 32'(bus.eng_abort), 32'd0);
        chk("rst busy",      32'(bus.busy),      32'd0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst rsp_data",  32'(bus.rsp_data),  32'd0);
        do_reset();

        // 1: single request, 100-cycle read, request dropped after the grant
        bus.req = 4'b0001;
        tick();
        chk("t1 start_latency", 32'(bus.eng_start), 32'd0);
        chk("t1 busy", 32'(bus.busy), 32'd1);
        tick();
        chk("t1 eng_start", 32'(bus.eng_start), 32'd1);
        chk("t1 eng_addr", 32'(bus.eng_addr), 32'h48);
        ns = n_start;
        bus.req = '0;
        repeat (99) tick();
        chk("t1 start_once", 32'(n_start), 32'(ns));
        bus.eng_done = 1'b1;
        bus.eng_data = 16'h1A80;
        tick();
        chk("t1 rsp_latency", 32'(bus.rsp_valid), 32'd0);
        bus.eng_done = 1'b0;
        bus.eng_data = 16'h5555;
        tick();
        chk_rsp("t1", 0, 1'b0, 16'h1A80);
        tick();
        chk("t1 rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        chk("t1 rsp_hold", 32'(bus.rsp_data), 32'h1A80);
        chk("t1 addr_hold", 32'(bus.eng_addr), 32'h48);
        chk("t1 idle", 32'(bus.busy), 32'd0);

        // 2: all requesting, strict rotation from id 0
        do_reset();
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            txn("t2", 4'b1111, 1'b0, $urandom_range(2, 30), 1'b0, 16'($urandom), w);
            chk("t2 order", 32'(w), 32'(k % NR));
            chk("t2 no_repeat", 32'(w != prev), 32'd1);
            prev = w;
        end

        // 3: NACK clears data
        txn("t3", 4'b0100, 1'b0, 7, 1'b1, 16'hFFFF, w);

        // Randomized traffic
        for (int k = 0; k < 25; k++) begin
            r = NR'($urandom_range(1, (1 << NR) - 1));
            d = 16'($urandom);
            txn("rnd", r, 1'($urandom), $urandom_range(1, 40), ($urandom_range(0, 5) == 0), d, w);
        end

        // 4: silent engine -> abort exactly TO cycles after start; late done ignored
        bus.req = 4'b0010;
        e = model_pick(bus.req);
        na = n_abort;
        wait_start("t4");
        model_grant(e);
        bus.req = '0;
        seen = 1'b0;
        for (int i = 0; i < TO + 5 && !seen; i++) begin
            tick();
            if (bus.eng_abort) seen = 1'b1;
        end
        chk("t4 abort_seen", 32'(seen), 32'd1);
        chk("t4 abort_delay", 32'(abort_cyc - start_cyc), 32'(TO));
        chk("t4 abort_once", 32'(n_abort - na), 32'd1);
        tick();
        chk_rsp("t4", e, 1'b1, 16'h0);
        chk("t4 abort_pulse", 32'(bus.eng_abort), 32'd0);
        bus.eng_done = 1'b1;
        bus.eng_data = 16'hBEEF;
        tick();
        bus.eng_done = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (bus.rsp_valid || bus.busy) seen = 1'b1;
        end
        chk("t4 late_done_ignored", 32'(seen), 32'd0);

        // 5a: done on the expiry cycle wins
        bus.req = 4'b0100;
        e = model_pick(bus.req);
        na = n_abort;
        wait_start("t5a");
        model_grant(e);
        bus.req = '0;
        repeat (TO - 1) tick();
        bus.eng_done = 1'b1;
        bus.eng_data = 16'h1234;
        tick();
        bus.eng_done = 1'b0;
        chk("t5a no_abort", 32'(bus.eng_abort), 32'd0);
        tick();
        chk_rsp("t5a", e, 1'b0, 16'h1234);
        chk("t5a abort_count", 32'(n_abort - na), 32'd0);

        // 5b: sched_en dropped mid-transaction
        bus.req = 4'b1000;
        e = model_pick(bus.req);
        wait_start("t5b");
        model_grant(e);
        bus.sched_en = 1'b0;
        respond(10, 1'b0, 16'h0C0F);
        chk_rsp("t5b", e, 1'b0, 16'h0C0F);
        ns = n_start;
        repeat (20) tick();
        chk("t5b no_grant", 32'(n_start), 32'(ns));
        chk("t5b idle", 32'(bus.busy), 32'd0);
        bus.sched_en = 1'b1;
        txn("t5b resume", 4'b1000, 1'b0, 4, 1'b0, 16'h7777, w);

        // 6: reset during WAIT
        txn("t6 pre", 4'b0100, 1'b0, 3, 1'b0, 16'h1111, w);
        bus.req = 4'b0010;
        wait_start("t6");
        reset_n = 1'b0;
        #1;
        chk("t6 eng_start", 32'(bus.eng_start), 32'd0);
        chk("t6 eng_addr",  32'(bus.eng_addr),  32'd0);
        chk("t6 busy",      32'(bus.busy),      32'd0);
        chk("t6 rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("t6 rsp_id",    32'(bus.rsp_id),    32'd0);
        bus.req = 4'b1111;
        tick();
        reset_n = 1'b1;
        model_grant(NR - 1);
        txn("t6 post", 4'b1111, 1'b0, 5, 1'b0, 16'h2222, w);
        chk("t6 first_grant", 32'(w), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
